conn_table_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the connection-table searcher. The receive parser (port 0) and the host/transmit path (port 1) submit lookup/insert or delete requests carrying a connection 5-tuple. The block serialises the requests and drives the searcher's tuple inputs stable for a programmable setup window before raising the request code. It then waits for the searcher's done and returns the connection ID and error code to the requester that owns the transaction.

---
 rtl/conn_table_arbiter_if.sv | 43 ++++
 rtl/conn_table_arbiter.sv | 169 ++++++++++++++++
 tb/tb_conn_table_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conn_table_arbiter_if.sv
// Request/response and searcher-side signal bundle for the connection-table arbiter.
// The arbiter binds to the slave modport; the requesters and searcher see the master view.
interface conn_table_arbiter_if;
  logic         ct_req0;
  logic         ct_req1;
  logic [1:0]   ct_op0;
  logic [1:0]   ct_op1;
  logic [143:0] ct_tuple0;
  logic [143:0] ct_tuple1;
  logic         ct_gnt0;
  logic         ct_gnt1;
  logic         ct_done0;
  logic         ct_done1;
  logic [7:0]   ct_id0;
  logic [7:0]   ct_id1;
  logic [7:0]   ct_err0;
  logic [7:0]   ct_err1;
  logic         ct_busy;
  logic [1:0]   sr_rq;
  logic [23:0]  sr_mac_src;
  logic [23:0]  sr_mac_dst;
  logic [31:0]  sr_ip_src;
  logic [31:0]  sr_ip_dst;
  logic [15:0]  sr_port_src;
  logic [15:0]  sr_port_dst;
  logic         sr_done;
  logic [7:0]   sr_id;
  logic [7:0]   sr_error;

  modport slave (
    input  ct_req0, ct_req1, ct_op0, ct_op1, ct_tuple0, ct_tuple1,
    input  sr_done, sr_id, sr_error,
    output ct_gnt0, ct_gnt1, ct_done0, ct_done1, ct_id0, ct_id1, ct_err0, ct_err1, ct_busy,
    output sr_rq, sr_mac_src, sr_mac_dst, sr_ip_src, sr_ip_dst, sr_port_src, sr_port_dst
  );

  modport master (
    output ct_req0, ct_req1, ct_op0, ct_op1, ct_tuple0, ct_tuple1,
    output sr_done, sr_id, sr_error,
    input  ct_gnt0, ct_gnt1, ct_done0, ct_done1, ct_id0, ct_id1, ct_err0, ct_err1, ct_busy,
    input  sr_rq, sr_mac_src, sr_mac_dst, sr_ip_src, sr_ip_dst, sr_port_src, sr_port_dst
  );
endinterface

// File: rtl/conn_table_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the connection-table searcher.
// Serialises requests, presents the tuple for a setup window, then issues and awaits done.
module conn_table_arbiter #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic                 ct_clk,
  input logic                 ct_rst_n,
  conn_table_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StSetup,
    StIssue,
    StResp
  } state_e;

  localparam logic [1:0] OpLookup    = 2'b01;
  localparam logic [1:0] OpDelete    = 2'b10;
  localparam logic [7:0] ErrTimeout  = 8'hFE;
  localparam logic [7:0] ErrBadOp    = 8'hFD;
  localparam logic [7:0] SetupLast   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_q, last_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   op_q, op_d;
  logic [143:0] tuple_q, tuple_d;
  logic [7:0]   id0_q, id0_d, err0_q, err0_d;
  logic [7:0]   id1_q, id1_d, err1_q, err1_d;

  logic [1:0]   cur_op;
  logic [143:0] cur_tuple;
  logic         op_valid;
  logic         rsp_we;
  logic [7:0]   rsp_id;
  logic [7:0]   rsp_err;

  assign cur_op    = owner_q ? bus.ct_op1 : bus.ct_op0;
  assign cur_tuple = owner_q ? bus.ct_tuple1 : bus.ct_tuple0;
  assign op_valid  = (cur_op == OpLookup) || (cur_op == OpDelete);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tuple_d = tuple_q;
    id0_d   = id0_q;
    err0_d  = err0_q;
    id1_d   = id1_q;
    err1_d  = err1_q;
    rsp_we  = 1'b0;
    rsp_id  = 8'h00;
    rsp_err = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (bus.ct_req0 || bus.ct_req1) begin
          // On contention the port that was not served last wins.
          owner_d = (bus.ct_req0 && bus.ct_req1) ? ~last_q : bus.ct_req1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        op_d = cur_op;
        if (op_valid) begin
          tuple_d = cur_tuple;
          cnt_d   = 8'h00;
          state_d = StSetup;
        end else begin
          // Invalid op never reaches the searcher; the tuple outputs keep their old value.
          rsp_we  = 1'b1;
          rsp_err = ErrBadOp;
          state_d = StResp;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = 8'h00;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIssue: begin
        if (bus.sr_done) begin
          rsp_we  = 1'b1;
          rsp_id  = bus.sr_id;
          rsp_err = bus.sr_error;
          cnt_d   = 8'h00;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          rsp_we  = 1'b1;
          rsp_err = ErrTimeout;
          cnt_d   = 8'h00;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Result registers are written one cycle early so they are valid alongside done.
    if (rsp_we) begin
      if (owner_q) begin
        id1_d  = rsp_id;
        err1_d = rsp_err;
      end else begin
        id0_d  = rsp_id;
        err0_d = rsp_err;
      end
    end
  end

  always_ff @(posedge ct_clk) begin
    if (!ct_rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'h00;
      op_q    <= 2'b00;
      tuple_q <= '0;
      id0_q   <= 8'h00;
      err0_q  <= 8'h00;
      id1_q   <= 8'h00;
      err1_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tuple_q <= tuple_d;
      id0_q   <= id0_d;
      err0_q  <= err0_d;
      id1_q   <= id1_d;
      err1_q  <= err1_d;
    end
  end

  assign bus.ct_gnt0     = (state_q == StGrant) && !owner_q;
  assign bus.ct_gnt1     = (state_q == StGrant) && owner_q;
  assign bus.ct_done0    = (state_q == StResp) && !owner_q;
  assign bus.ct_done1    = (state_q == StResp) && owner_q;
  assign bus.ct_id0      = id0_q;
  assign bus.ct_err0     = err0_q;
  assign bus.ct_id1      = id1_q;
  assign bus.ct_err1     = err1_q;
  assign bus.ct_busy     = (state_q != StIdle);
  assign bus.sr_rq       = (state_q == StIssue) ? op_q : 2'b00;
  assign bus.sr_mac_src  = tuple_q[143:120];
  assign bus.sr_mac_dst  = tuple_q[119:96];
  assign bus.sr_ip_src   = tuple_q[95:64];
  assign bus.sr_ip_dst   = tuple_q[63:32];
  assign bus.sr_port_src = tuple_q[31:16];
  assign bus.sr_port_dst = tuple_q[15:0];

endmodule

// File: tb/tb_conn_table_arbiter.sv
// Self-checking bench for conn_table_arbiter: table-driven transactions, a scoreboard of
// expected grants/results, a searcher model, and hand-written timing/timeout/reset sequences.
module tb_conn_table_arbiter;

  localparam int Tmo = 10;

  typedef struct {
    bit           r0;
    bit           r1;
    logic [1:0]   op0;
    logic [1:0]   op1;
    logic [143:0] t0;
    logic [143:0] t1;
    int           lat;
    int           first;
  } vec_t;

  typedef struct {
    int           port;
    logic [1:0]   op;
    logic [143:0] tuple;
    logic [7:0]   id;
    logic [7:0]   err;
    int           rq_cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conn_table_arbiter_if bus ();

  conn_table_arbiter #(
    .SETUP_CYCLES(2),
    .TIMEOUT     (Tmo)
  ) dut (
    .ct_clk  (clk),
    .ct_rst_n(rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int dones = 0;
  int rq_run = 0;
  int sr_lat = 0;
  int rq_age = 0;
  logic mdl_done = 1'b0;
  logic stray_done = 1'b0;
  logic [7:0] mdl_id = 8'h00;
  logic [7:0] mdl_err = 8'h00;
  logic [7:0] id_sh [2];
  logic [7:0] err_sh [2];
  exp_t res_q[$];
  int gnt_q[$];
  vec_t tbl[6];
  logic [143:0] sr_tuple;
  logic [182:0] all_out;

  assign bus.sr_done  = mdl_done | stray_done;
  assign bus.sr_id    = mdl_id;
  assign bus.sr_error = mdl_err;
  assign sr_tuple = {bus.sr_mac_src, bus.sr_mac_dst, bus.sr_ip_src, bus.sr_ip_dst,
                     bus.sr_port_src, bus.sr_port_dst};
  assign all_out = {bus.ct_gnt0, bus.ct_gnt1, bus.ct_done0, bus.ct_done1, bus.ct_id0,
                    bus.ct_id1, bus.ct_err0, bus.ct_err1, bus.ct_busy, bus.sr_rq, sr_tuple};

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] mk_tuple(input logic [7:0] idv, input logic [7:0] errv,
                                            input logic [31:0] salt);
    return {salt[23:0], ~salt[23:0], salt, ~salt, {8'h5A, errv}, {8'hC3, idv}};
  endfunction

  // Searcher contract: id = low byte of port_dst, error = low byte of port_src.
  function automatic exp_t mk_exp(input int p, input logic [1:0] op, input logic [143:0] t,
                                  input int lat);
    exp_t e;
    e.port  = p;
    e.op    = op;
    e.tuple = t;
    if (op == 2'b01 || op == 2'b10) begin
      if (lat < 0) begin
        e.id = 8'h00; e.err = 8'hFE; e.rq_cycles = Tmo;
      end else begin
        e.id = t[7:0]; e.err = t[23:16]; e.rq_cycles = lat + 1;
      end
    end else begin
      e.id = 8'h00; e.err = 8'hFD; e.rq_cycles = 0;
    end
    return e;
  endfunction

  // Searcher model: done pulses sr_lat cycles after sr_rq first goes non-zero (never if < 0).
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (bus.sr_rq != 2'b00) begin
      if (sr_lat >= 0 && rq_age == sr_lat) begin
        mdl_done = 1'b1;
        mdl_id   = bus.sr_port_dst[7:0];
        mdl_err  = bus.sr_port_src[7:0];
      end
      rq_age++;
    end else begin
      rq_age = 0;
    end
  end

  exp_t mon_e;
  int   mon_p;
  int   mon_g;
  always @(negedge clk) begin
    if (bus.ct_gnt0 || bus.ct_gnt1) begin
      check("gnt_onehot", 192'(bus.ct_gnt0 & bus.ct_gnt1), 192'd0);
      if (gnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL gnt_unexpected got gnt0=%0b gnt1=%0b want none", bus.ct_gnt0,
                 bus.ct_gnt1);
      end else begin
        mon_g = gnt_q.pop_front();
        check("gnt_port", 192'(bus.ct_gnt1), 192'(mon_g));
      end
    end
    if (bus.sr_rq != 2'b00) begin
      rq_run++;
      if (res_q.size() != 0) begin
        check("sr_rq_op", 192'(bus.sr_rq), 192'(res_q[0].op));
        check("sr_tuple_hold", 192'(sr_tuple), 192'(res_q[0].tuple));
      end
    end
    if (bus.ct_done0 || bus.ct_done1) begin
      dones++;
      mon_p = bus.ct_done1 ? 1 : 0;
      check("done_onehot", 192'(bus.ct_done0 & bus.ct_done1), 192'd0);
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected got done on port %0d want none", mon_p);
      end else begin
        mon_e = res_q.pop_front();
        check("done_port", 192'(mon_p), 192'(mon_e.port));
        check("done_id", 192'(mon_p ? bus.ct_id1 : bus.ct_id0), 192'(mon_e.id));
        check("done_err", 192'(mon_p ? bus.ct_err1 : bus.ct_err0), 192'(mon_e.err));
        check("other_id_kept", 192'(mon_p ? bus.ct_id0 : bus.ct_id1), 192'(id_sh[1-mon_p]));
        check("other_err_kept", 192'(mon_p ? bus.ct_err0 : bus.ct_err1),
              192'(err_sh[1-mon_p]));
        check("rq_cycles", 192'(rq_run), 192'(mon_e.rq_cycles));
        id_sh[mon_e.port]  = mon_e.id;
        err_sh[mon_e.port] = mon_e.err;
      end
      rq_run = 0;
    end
  end

  task automatic clear_sb();
    res_q.delete();
    gnt_q.delete();
    rq_run = 0;
    id_sh[0] = 8'h00; id_sh[1] = 8'h00;
    err_sh[0] = 8'h00; err_sh[1] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ct_req0 = 1'b0;
    bus.ct_req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 192'(all_out), 192'd0);
    clear_sb();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle_busy", 192'(bus.ct_busy), 192'd0);
  endtask

  // Queues the expectations for one table row, drives it, and waits for every done.
  task automatic run_row(input vec_t v);
    int want;
    int n;
    bit s0;
    bit s1;
    n = int'(v.r0) + int'(v.r1);
    s0 = 1'b0;
    s1 = 1'b0;
    sr_lat = v.lat;
    if (v.r0 && v.r1) begin
      gnt_q.push_back(v.first);
      gnt_q.push_back(1 - v.first);
      if (v.first == 0) begin
        res_q.push_back(mk_exp(0, v.op0, v.t0, v.lat));
        res_q.push_back(mk_exp(1, v.op1, v.t1, v.lat));
      end else begin
        res_q.push_back(mk_exp(1, v.op1, v.t1, v.lat));
        res_q.push_back(mk_exp(0, v.op0, v.t0, v.lat));
      end
    end else if (v.r0) begin
      gnt_q.push_back(0);
      res_q.push_back(mk_exp(0, v.op0, v.t0, v.lat));
    end else begin
      gnt_q.push_back(1);
      res_q.push_back(mk_exp(1, v.op1, v.t1, v.lat));
    end
    want = dones + n;
    bus.ct_op0 = v.op0; bus.ct_tuple0 = v.t0; bus.ct_req0 = v.r0;
    bus.ct_op1 = v.op1; bus.ct_tuple1 = v.t1; bus.ct_req1 = v.r1;
    for (int c = 0; c < 300 && dones < want; c++) begin
      @(negedge clk);
      // Corrupt the requester's tuple once it has been captured.
      if (s0) begin bus.ct_tuple0 = ~bus.ct_tuple0; s0 = 1'b0; end
      if (s1) begin bus.ct_tuple1 = ~bus.ct_tuple1; s1 = 1'b0; end
      if (bus.ct_gnt0) begin bus.ct_req0 = 1'b0; s0 = 1'b1; end
      if (bus.ct_gnt1) begin bus.ct_req1 = 1'b0; s1 = 1'b1; end
    end
    check("row_completed", 192'(dones >= want), 192'd1);
    bus.ct_req0 = 1'b0;
    bus.ct_req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [143:0] ta;
    vec_t v;
    bit hit;
    bus.ct_req0 = 1'b0; bus.ct_req1 = 1'b0;
    bus.ct_op0 = 2'b00; bus.ct_op1 = 2'b00;
    bus.ct_tuple0 = '0; bus.ct_tuple1 = '0;
    clear_sb();

    tbl[0] = '{1'b1, 1'b1, 2'b01, 2'b10, mk_tuple(8'h11, 8'h21, 32'h1000_0001),
               mk_tuple(8'h12, 8'h22, 32'h2000_0002), 1, 0};
    tbl[1] = '{1'b1, 1'b1, 2'b10, 2'b01, mk_tuple(8'h13, 8'h23, 32'h3000_0003),
               mk_tuple(8'h14, 8'h24, 32'h4000_0004), 0, 0};
    tbl[2] = '{1'b0, 1'b1, 2'b00, 2'b11, '0, mk_tuple(8'h77, 8'h66, 32'hDEAD_BEEF), 2, 1};
    tbl[3] = '{1'b1, 1'b0, 2'b01, 2'b00, mk_tuple(8'h15, 8'h25, 32'h5000_0005), '0, 5, 0};
    tbl[4] = '{1'b1, 1'b1, 2'b01, 2'b01, mk_tuple(8'h16, 8'h26, 32'h6000_0006),
               mk_tuple(8'h17, 8'h27, 32'h7000_0007), 2, 1};
    tbl[5] = '{1'b1, 1'b0, 2'b00, 2'b00, mk_tuple(8'h99, 8'h88, 32'h0BAD_0BAD), '0, 1, 0};

    do_reset();

    // Port 0 alone, op 01, searcher answers 3 cycles after rq: cycle-exact latency checks.
    ta = {24'h111111, 24'h222222, 32'h0A00_0001, 32'h0A00_0002, 16'h1203, 16'h0505};
    sr_lat = 3;
    gnt_q.push_back(0);
    res_q.push_back(mk_exp(0, 2'b01, ta, 3));
    bus.ct_op0 = 2'b01; bus.ct_tuple0 = ta; bus.ct_req0 = 1'b1;     // cycle N
    @(negedge clk);                                                  // N+1
    check("t1_gnt0", 192'(bus.ct_gnt0), 192'd1);
    check("t1_sr_rq_grant", 192'(bus.sr_rq), 192'd0);
    bus.ct_req0 = 1'b0;
    @(negedge clk);                                                  // N+2
    bus.ct_tuple0 = ~ta;
    check("t1_tuple_n2", 192'(sr_tuple), 192'(ta));
    check("t1_rq_n2", 192'(bus.sr_rq), 192'd0);
    @(negedge clk);                                                  // N+3
    check("t1_rq_n3", 192'(bus.sr_rq), 192'd0);
    check("t1_tuple_n3", 192'(sr_tuple), 192'(ta));
    @(negedge clk);                                                  // N+4
    check("t1_rq_n4", 192'(bus.sr_rq), 192'd1);
    repeat (4) @(negedge clk);                                       // N+8
    check("t1_done0", 192'(bus.ct_done0), 192'd1);
    check("t1_id0", 192'(bus.ct_id0), 192'h05);
    check("t1_err0", 192'(bus.ct_err0), 192'h03);
    check("t1_busy_resp", 192'(bus.ct_busy), 192'd1);
    @(negedge clk);                                                  // N+9
    check("t1_busy_low", 192'(bus.ct_busy), 192'd0);
    check("t1_rq_low", 192'(bus.sr_rq), 192'd0);

    do_reset();
    for (int i = 0; i < 6; i++) run_row(tbl[i]);

    // Timeout: searcher never answers; then a stray sr_done must change nothing.
    v = '{1'b1, 1'b0, 2'b10, 2'b00, mk_tuple(8'h31, 8'h32, 32'h0C0C_0C0C), '0, -1, 0};
    run_row(v);
    @(negedge clk);
    mdl_id = 8'hAA;
    mdl_err = 8'hBB;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_busy", 192'(bus.ct_busy), 192'd0);
    check("stray_id0", 192'(bus.ct_id0), 192'h00);
    check("stray_err0", 192'(bus.ct_err0), 192'hFE);
    check("stray_rq", 192'(bus.sr_rq), 192'd0);

    // Reset for one cycle while in ISSUE abandons the transaction.
    sr_lat = -1;
    gnt_q.push_back(0);
    res_q.push_back(mk_exp(0, 2'b01, ta, -1));
    bus.ct_op0 = 2'b01; bus.ct_tuple0 = ta; bus.ct_req0 = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (bus.ct_gnt0) bus.ct_req0 = 1'b0;
      if (bus.sr_rq != 2'b00) hit = 1'b1;
    end
    check("rst_reached_issue", 192'(hit), 192'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_issue_outputs", 192'(all_out), 192'd0);
    clear_sb();
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_no_resume", 192'(bus.ct_busy), 192'd0);
    v = '{1'b1, 1'b1, 2'b01, 2'b01, mk_tuple(8'h41, 8'h42, 32'h0D0D_0D0D),
          mk_tuple(8'h43, 8'h44, 32'h0E0E_0E0E), 1, 0};
    run_row(v);

    check("sb_empty", 192'(res_q.size() + gnt_q.size()), 192'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
